// File: rtl/mod_controller_scheduler.sv
// Poll scheduler for two NES pads sharing one latch/pulse pair.
// Runs frame-scheduled or forced polls, deserializes both data lines and publishes snapshots plus newly-pressed masks.
module mod_controller_scheduler #(
   parameter int CLK_DIV    = 6,
   parameter int POLL_EVERY = 1
) (
   input  logic       in_clk_controller,
   input  logic       in_rst_n,
   input  logic       in_vsync,
   input  logic       in_force_poll,
   input  logic [1:0] in_pad_data,
   output logic       out_controller_latch,
   output logic       out_controller_pulse,
   output logic [7:0] out_buttons0,
   output logic [7:0] out_buttons1,
   output logic [7:0] out_pressed0,
   output logic [7:0] out_pressed1,
   output logic       out_valid,
   output logic       out_busy
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LATCH    = 3'd1;
   localparam logic [2:0] ST_GAP      = 3'd2;
   localparam logic [2:0] ST_PULSE_HI = 3'd3;
   localparam logic [2:0] ST_PULSE_LO = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   localparam logic [7:0] PH_RELOAD  = 8'(CLK_DIV - 1);
   localparam logic [3:0] FRAME_LAST = 4'(POLL_EVERY - 1);

   logic [2:0] state_r, state_s;
   logic [7:0] phase_r;
   logic       half_r;
   logic [2:0] bit_cnt_r;
   logic [7:0] shift0_r, shift1_r, shift0_s, shift1_s;
   logic       pending_r, pending_s;
   logic [3:0] frame_cnt_r;
   logic       vsync_prev_r;
   logic       frame_evt_s, sched_s, trigger_s, phase_end_s, sample_s, state_chg_s;

   // Next-state, trigger and sampling decode
   always_comb begin
      frame_evt_s = vsync_prev_r & ~in_vsync;
      sched_s     = frame_evt_s && (frame_cnt_r == FRAME_LAST);
      trigger_s   = sched_s | in_force_poll;
      phase_end_s = (phase_r == 8'd0);
      shift0_s    = {~in_pad_data[0], shift0_r[7:1]};
      shift1_s    = {~in_pad_data[1], shift1_r[7:1]};
      sample_s    = 1'b0;
      state_s     = state_r;
      case (state_r)
         ST_IDLE: begin
            if (trigger_s || pending_r) state_s = ST_LATCH;
            else                        state_s = ST_IDLE;
         end
         // Latch spans two phase periods so the phase counter stays 8 bits wide
         ST_LATCH: begin
            if (phase_end_s && half_r) state_s = ST_GAP;
            else                       state_s = ST_LATCH;
         end
         ST_GAP: begin
            if (phase_end_s) begin
               state_s  = ST_PULSE_HI;
               sample_s = 1'b1;
            end else begin
               state_s  = ST_GAP;
            end
         end
         ST_PULSE_HI: begin
            if (phase_end_s) state_s = ST_PULSE_LO;
            else             state_s = ST_PULSE_HI;
         end
         ST_PULSE_LO: begin
            if (phase_end_s) begin
               sample_s = 1'b1;
               if (bit_cnt_r == 3'd7) state_s = ST_DONE;
               else                   state_s = ST_PULSE_HI;
            end else begin
               state_s = ST_PULSE_LO;
            end
         end
         ST_DONE: begin
            if (pending_r) state_s = ST_LATCH;
            else           state_s = ST_IDLE;
         end
         default: state_s = ST_IDLE;
      endcase
      state_chg_s = (state_s != state_r);
      // Starting a poll absorbs every trigger that is still pending
      if (state_chg_s && (state_s == ST_LATCH)) pending_s = 1'b0;
      else if ((state_r != ST_IDLE) && trigger_s) pending_s = 1'b1;
      else pending_s = pending_r;
   end

   // Vsync edge tracking and frame divider
   always_ff @(posedge in_clk_controller or negedge in_rst_n) begin
      if (!in_rst_n) begin
         vsync_prev_r <= 1'b1;
         frame_cnt_r  <= 4'd0;
      end else begin
         vsync_prev_r <= in_vsync;
         if (frame_evt_s) begin
            if (sched_s) frame_cnt_r <= 4'd0;
            else         frame_cnt_r <= frame_cnt_r + 4'd1;
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
      end
   end

   // Sequencer state, phase timing, bit counting and shift registers
   always_ff @(posedge in_clk_controller or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_r   <= ST_IDLE;
         pending_r <= 1'b0;
         phase_r   <= 8'd0;
         half_r    <= 1'b0;
         bit_cnt_r <= 3'd0;
         shift0_r  <= 8'd0;
         shift1_r  <= 8'd0;
      end else begin
         state_r   <= state_s;
         pending_r <= pending_s;
         if (state_chg_s) begin
            phase_r <= PH_RELOAD;
            half_r  <= 1'b0;
         end else if (phase_end_s && (state_r == ST_LATCH)) begin
            phase_r <= PH_RELOAD;
            half_r  <= 1'b1;
         end else if (!phase_end_s) begin
            phase_r <= phase_r - 8'd1;
         end
         if (state_chg_s && (state_s == ST_LATCH)) bit_cnt_r <= 3'd0;
         else if (sample_s)                        bit_cnt_r <= bit_cnt_r + 3'd1;
         if (sample_s) begin
            shift0_r <= shift0_s;
            shift1_r <= shift1_s;
         end
      end
   end

   // Registered pad lines, status and snapshot publication
   always_ff @(posedge in_clk_controller or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_controller_latch <= 1'b0;
         out_controller_pulse <= 1'b0;
         out_busy             <= 1'b0;
         out_valid            <= 1'b0;
         out_buttons0         <= 8'd0;
         out_buttons1         <= 8'd0;
         out_pressed0         <= 8'd0;
         out_pressed1         <= 8'd0;
      end else begin
         out_controller_latch <= (state_s == ST_LATCH);
         out_controller_pulse <= (state_s == ST_PULSE_HI);
         out_busy             <= (state_s != ST_IDLE);
         out_valid            <= (state_s == ST_DONE);
         // DONE is only entered on the bit-7 sample, so shift*_s holds the full snapshot
         if (state_s == ST_DONE) begin
            out_buttons0 <= shift0_s;
            out_buttons1 <= shift1_s;
            out_pressed0 <= shift0_s & ~out_buttons0;
            out_pressed1 <= shift1_s & ~out_buttons1;
         end
      end
   end

endmodule

// File: tb/tb_mod_controller_scheduler.sv
// Scoreboard bench: two scheduler instances (CLK_DIV=2/POLL_EVERY=3 and CLK_DIV=1/POLL_EVERY=1)
// driven by shared vsync/force stimulus, each with its own pad model and poll-level reference model.
module tb_mod_controller_scheduler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic vsync = 1'b1;
   logic force_poll = 1'b0;
   logic fin = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d cyc=%0d actual=%0h expected=%0h", name, g, cyc, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : gi
      localparam int CD = (g == 0) ? 2 : 1;
      localparam int PE = (g == 0) ? 3 : 1;

      logic       latch, pulse, valid, busy;
      logic [7:0] b0, b1, p0, p1;
      logic [1:0] pad = 2'b11;

      mod_controller_scheduler #(.CLK_DIV(CD), .POLL_EVERY(PE)) dut (
         .in_clk_controller   (clk),
         .in_rst_n            (rst_n),
         .in_vsync            (vsync),
         .in_force_poll       (force_poll),
         .in_pad_data         (pad),
         .out_controller_latch(latch),
         .out_controller_pulse(pulse),
         .out_buttons0        (b0),
         .out_buttons1        (b1),
         .out_pressed0        (p0),
         .out_pressed1        (p1),
         .out_valid           (valid),
         .out_busy            (busy)
      );

      logic [31:0] sb[$];
      logic [7:0]  btn0 = 8'd0, btn1 = 8'd0, sh0 = 8'd0, sh1 = 8'd0, prev0 = 8'd0, prev1 = 8'd0;
      logic [31:0] exp_out = 32'd0;
      logic        pulse_d = 1'b0;
      int          poll_start = -1;
      int          frames = 0;
      int          polls = 0;
      bit          pend = 1'b0;
      bit          vs_d = 1'b1;
      bit          end_chk = 1'b0;

      task automatic start_poll();
         poll_start = cyc + 1;
         if (polls < 2) begin
            btn0 = 8'h81;
            btn1 = 8'h00;
         end else begin
            btn0 = 8'($urandom);
            btn1 = 8'($urandom);
         end
         polls++;
         sb.push_back({btn1 & ~prev1, btn0 & ~prev0, btn1, btn0});
         prev0 = btn0;
         prev1 = btn1;
      endtask

      always @(negedge clk) begin
         int o;
         bit act, trig, fe;
         if (!rst_n) begin
            chk("rst_ctrl", g, {28'd0, latch, pulse, valid, busy}, 32'd0);
            chk("rst_snap", g, {p1, p0, b1, b0}, 32'd0);
            poll_start = -1;
            pend = 1'b0;
            frames = 0;
            vs_d = 1'b1;
            sb.delete();
            prev0 = 8'd0;
            prev1 = 8'd0;
            exp_out = 32'd0;
            pulse_d = 1'b0;
         end else begin
            act = (poll_start >= 0) && (cyc >= poll_start);
            o = cyc - poll_start;
            chk("latch", g, 32'(latch), 32'(act && (o < 2 * CD)));
            chk("pulse", g, 32'(pulse),
                32'(act && (o >= 3 * CD) && (o < 17 * CD) && (((o - 3 * CD) / CD) % 2 == 0)));
            chk("valid", g, 32'(valid), 32'(act && (o == 17 * CD)));
            chk("busy", g, 32'(busy), 32'(act));
            if (valid) begin
               if (sb.size() == 0) chk("sb_nonempty", g, 32'(sb.size()), 32'd1);
               else exp_out = sb.pop_front();
            end
            chk("snapshot", g, {p1, p0, b1, b0}, exp_out);

            // NES pad: parallel load while latched, shift on each pulse rise, line low = pressed
            if (latch) begin
               sh0 = btn0;
               sh1 = btn1;
            end else if (pulse && !pulse_d) begin
               sh0 = sh0 >> 1;
               sh1 = sh1 >> 1;
            end
            pulse_d = pulse;
            pad = {~sh1[0], ~sh0[0]};

            // Poll-level model: a poll occupies 17*CD+1 cycles from its start
            fe = vs_d && !vsync;
            if (fe) frames++;
            trig = force_poll || (fe && (frames % PE == 0));
            vs_d = vsync;
            if (act && (o == 17 * CD)) begin
               if (pend) begin
                  pend = 1'b0;
                  start_poll();
               end else begin
                  poll_start = -1;
                  pend = trig;
               end
            end else if (act) begin
               if (trig) pend = 1'b1;
            end else if (trig || pend) begin
               pend = 1'b0;
               start_poll();
            end
         end
         if (fin && !end_chk) begin
            end_chk = 1'b1;
            chk("sb_drained", g, 32'(sb.size()), 32'd0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic force_pulse();
      @(posedge clk); #1 force_poll = 1'b1;
      @(posedge clk); #1 force_poll = 1'b0;
   endtask

   task automatic vsync_edge();
      @(posedge clk); #1 vsync = 1'b0;
      repeat (4) @(posedge clk);
      #1 vsync = 1'b1;
   endtask

   initial begin
      idle(3);
      #1 rst_n = 1'b1;
      idle(5);
      // two identical directed polls: A+Right on pad0
      force_pulse();
      idle(60);
      force_pulse();
      idle(60);
      for (int i = 0; i < 7; i++) begin
         vsync_edge();
         idle(50);
      end
      // frame edge and force together while busy: coalesce into one pending poll
      force_pulse();
      idle(5);
      @(posedge clk); #1 vsync = 1'b0; force_poll = 1'b1;
      @(posedge clk); #1 force_poll = 1'b0;
      idle(3);
      #1 vsync = 1'b1;
      idle(100);
      // reset in PULSE_HI of bit 4 of the CLK_DIV=2 instance
      @(posedge clk); #1 force_poll = 1'b1;
      @(posedge clk); #1 force_poll = 1'b0;
      repeat (18) @(posedge clk);
      #1 rst_n = 1'b0;
      idle(2);
      #1 rst_n = 1'b1;
      force_pulse();
      idle(60);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         force_poll = ($urandom_range(0, 24) == 0);
         vsync = ($urandom_range(0, 11) != 0);
      end
      @(posedge clk); #1 force_poll = 1'b0; vsync = 1'b1;
      idle(120);
      fin = 1'b1;
      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_controller_scheduler.md
# mod_controller_scheduler

Frame-synchronized poll scheduler for two NES pads sharing one latch/pulse pair. It sequences the latch and pulse lines at a programmable bit rate and triggers a poll every POLL_EVERY frames or on demand. Both serial data lines are deserialized in parallel. Each completed poll publishes a button snapshot and a newly-pressed mask for the CPU-side input registers.

## Interface
- CLK_DIV, default 6: cycles per latch/pulse half-phase; legal 1..255.
- POLL_EVERY, default 1: vsync frames between scheduled polls; legal 1..15.
- in_clk_controller  in  1  block clock; all inputs synchronous to it.
- in_rst_n  in  1  asynchronous, active-low reset.
- in_vsync  in  1  active-low vsync; a 1→0 transition marks a frame.
- in_force_poll  in  1  one-cycle request for an immediate poll.
- in_pad_data  in  2  serial data, bit0 = pad0, bit1 = pad1; line low = button pressed.
- out_controller_latch  out  1  shared latch to both pads.
- out_controller_pulse  out  1  shared shift pulse to both pads.
- out_buttons0, out_buttons1  out  8  snapshot, 1 = pressed; [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- out_pressed0, out_pressed1  out  8  buttons pressed in this snapshot and released in the previous one.
- out_valid  out  1  one-cycle strobe when a new snapshot is published.
- out_busy  out  1  high while a poll sequence is in progress.

## Operation
- Reset (asynchronous, immediate): all outputs 0, FSM in IDLE, frame counter 0, pending flag 0, previous-vsync register 1.
- Frame detect: register in_vsync; frame event = prev 1 and current 0.
- Frame counter, 4-bit:
  - Increments on each frame event.
  - On the event at which it equals POLL_EVERY-1, it wraps to 0 and raises a scheduled trigger.
- Trigger = scheduled trigger OR in_force_poll.
  - In IDLE, a trigger starts a poll on the next cycle.
  - In any other state, a trigger sets the pending flag. Multiple triggers coalesce into one pending poll.
- FSM states: IDLE, LATCH, GAP, PULSE_HI, PULSE_LO, DONE.
  - IDLE → LATCH on trigger or pending. Entering LATCH clears pending.
  - LATCH: latch=1 for 2·CLK_DIV cycles, then → GAP.
  - GAP: latch=0 for CLK_DIV cycles. On the last GAP cycle, sample in_pad_data as bit 0, then → PULSE_HI.
  - PULSE_HI: pulse=1 for CLK_DIV cycles, then → PULSE_LO.
  - PULSE_LO: pulse=0 for CLK_DIV cycles. On the last cycle, sample the next bit. After bit 7 is sampled → DONE; otherwise → PULSE_HI.
  - DONE (one cycle): publish the snapshot and strobe out_valid, then → IDLE. If pending=1, go directly to LATCH instead.
- Sampling:
  - Each sample shifts right into a per-pad 8-bit register: new = {~data, reg[7:1]}. After 8 samples, bit0 = A.
  - Data is inverted so that 1 = pressed.
- Publish, in DONE:
  - out_pressedN = shiftN & ~out_buttonsN, using the old value of out_buttonsN.
  - out_buttonsN = shiftN.
  - Both outputs hold until the next DONE.
- out_busy = 1 in every state except IDLE.
- Exactly 7 pulses per poll; no pulse follows bit 7.
- Phase counter is 8 bits and reloads to CLK_DIV-1 on every state change.
- Bit counter is 3 bits and counts the sampled bits.

## Timing
- Trigger seen in cycle T → latch rises in cycle T+1.
- Latch high: T+1 .. T+2·CLK_DIV.
- Bit 0 sampled at cycle T+3·CLK_DIV.
- Bit k (1..7) sampled at cycle T+3·CLK_DIV+2k·CLK_DIV.
- Bit 7 sampled at T+17·CLK_DIV; DONE/out_valid at T+17·CLK_DIV+1.
- Poll latency from trigger to out_valid: 17·CLK_DIV+1 cycles. At CLK_DIV=6 this is 103 cycles.
- Back-to-back polls (pending set): latch rises the cycle after DONE.
- A frame event coinciding with in_force_poll produces one poll.
- A frame event during DONE sets pending.
- Reset mid-poll: latch and pulse drop asynchronously. Snapshots and pressed masks clear to 0, and no out_valid is produced.

## Test plan
- Reset, then in_force_poll at CLK_DIV=2. Pad0 serial stream 0,1,1,1,1,1,1,0 (A and Right pressed). → latch high 4 cycles; 7 pulses each 2 high/2 low; out_valid 35 cycles after the trigger; out_buttons0=8'h81, out_pressed0=8'h81.
- Repeat the same stream on the next poll. → out_buttons0=8'h81, out_pressed0=8'h00. Pad1 held high throughout → out_buttons1=8'h00.
- POLL_EVERY=3 with 7 vsync falling edges. → polls start after edges 3 and 6 only.
- Vsync falling edge and in_force_poll while busy. → single pending poll; its latch rises the cycle after DONE; total 2 out_valid strobes.
- Assert in_rst_n=0 during PULSE_HI of bit 4. → latch, pulse, busy and all snapshots go to 0 immediately. After release, the next force poll runs a full 8-bit sequence.
- CLK_DIV=1 with a single force poll. → out_valid exactly 18 cycles after the trigger; pulse toggles every cycle.
